// File: rtl/param_muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add (MUL) or restoring (DIV) step per cycle
// on operand magnitudes, with sign correction in a final FIX cycle.
module param_muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d, dsign_q, dsign_d, isdiv_q, isdiv_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_q, dbz_d;

    logic [WIDTH-1:0]   a_mag, b_mag, diff, quot, rem;
    logic [WIDTH:0]     sum, rem_sh;
    logic               ge;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opd_q   <= '0;
            araw_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            dsign_q <= 1'b0;
            isdiv_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opd_q   <= opd_d;
            araw_q  <= araw_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            dsign_q <= dsign_d;
            isdiv_q <= isdiv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = op[0] ? DIV : MUL;
            MUL,
            DIV:     if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == MUL) || (state_q == DIV);
        done        = done_q;
        hi          = hi_q;
        lo          = lo_q;
        div_by_zero = dbz_q;
    end

    // Datapath: signed ops run on magnitudes; the signs are reapplied in FIX.
    always_comb begin
        cnt_d   = cnt_q;
        opd_d   = opd_q;
        araw_d  = araw_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        dsign_d = dsign_q;
        isdiv_d = isdiv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        a_mag  = (!op[1] && a[WIDTH-1]) ? -a : a;
        b_mag  = (!op[1] && b[WIDTH-1]) ? -b : b;
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, opd_q};
        diff   = rem_sh[WIDTH-1:0] - opd_q;
        prod   = neg_q ? -acc_q : acc_q;
        quot   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem    = dsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            IDLE: if (start) begin
                cnt_d   = CNT_W'(WIDTH);
                araw_d  = a;
                isdiv_d = op[0];
                neg_d   = !op[1] && (a[WIDTH-1] ^ b[WIDTH-1]);
                dsign_d = !op[1] && a[WIDTH-1];
                // MUL: multiplier in the low half, multiplicand held aside.
                // DIV: dividend in the low half (quotient side), divisor held aside.
                opd_d   = op[0] ? b_mag : a_mag;
                acc_d   = {{WIDTH{1'b0}}, op[0] ? a_mag : b_mag};
            end
            MUL: begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
            end
            DIV: begin
                acc_d = {ge ? diff : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
                cnt_d = cnt_q - CNT_W'(1);
            end
            FIX: begin
                done_d = 1'b1;
                dbz_d  = isdiv_q && (opd_q == '0);
                if (!isdiv_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (opd_q == '0) begin
                    hi_d = araw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quot;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_param_muldiv_unit.sv
// Randomized bench for param_muldiv_unit (WIDTH=32 and WIDTH=8 instances)
// checked against an integer-arithmetic reference model.
module tb_param_muldiv_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear, start_in, sel8;
    logic [1:0]  op_in;
    logic [31:0] a_in, b_in;
    logic        busy32, done32, dbz32, busy8, done8, dbz8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic        busy_o, done_o, dbz_o;
    logic [31:0] hi_o, lo_o, prev_hi, prev_lo;
    int          checks = 0;
    int          errors = 0;

    param_muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .clear(clear), .start(start_in & ~sel8), .op(op_in),
        .a(a_in), .b(b_in), .busy(busy32), .done(done32),
        .hi(hi32), .lo(lo32), .div_by_zero(dbz32));

    param_muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .clear(clear), .start(start_in & sel8), .op(op_in),
        .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy8), .done(done8),
        .hi(hi8), .lo(lo8), .div_by_zero(dbz8));

    assign busy_o = sel8 ? busy8 : busy32;
    assign done_o = sel8 ? done8 : done32;
    assign dbz_o  = sel8 ? dbz8  : dbz32;
    assign hi_o   = sel8 ? {24'h0, hi8} : hi32;
    assign lo_o   = sel8 ? {24'h0, lo8} : lo32;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on w-bit values.
    function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo, output logic dbz);
        longint mask = (longint'(1) << w) - 1;
        longint ua = longint'(a) & mask;
        longint ub = longint'(b) & mask;
        longint sa = ua, sb = ub, p;
        if (!op[1]) begin
            if (ua[w-1]) sa = ua - (longint'(1) << w);
            if (ub[w-1]) sb = ub - (longint'(1) << w);
        end
        dbz = 1'b0;
        if (!op[0]) begin
            p  = sa * sb;
            hi = 32'((p >> w) & mask);
            lo = 32'(p & mask);
        end else if (ub == 0) begin
            hi  = 32'(ua);
            lo  = 32'(mask);
            dbz = 1'b1;
        end else begin
            hi = 32'((sa % sb) & mask);
            lo = 32'((sa / sb) & mask);
        end
    endfunction

    // Issues one op (caller is just after an edge); returns just after the done edge,
    // so a following call starts in the done cycle.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke);
        int w = sel8 ? 8 : 32;
        logic [31:0] eh, el;
        logic edz;
        int lat = 0, nbusy = 0;
        model(w, op, a, b, eh, el, edz);
        start_in = 1'b1; op_in = op; a_in = a; b_in = b;
        @(posedge clk); #1;
        start_in = 1'b0; a_in = $urandom; b_in = $urandom; op_in = 2'($urandom);
        for (int k = 1; k <= 3 * w && lat == 0; k++) begin
            if (k == 1) chk("done_pulse", {63'b0, done_o}, 64'd0);
            if (k == w / 2) begin
                chk("hold_hi", {32'b0, hi_o}, {32'b0, prev_hi});
                chk("hold_lo", {32'b0, lo_o}, {32'b0, prev_lo});
            end
            if (busy_o) nbusy++;
            if (poke && k == 5) start_in = 1'b1;
            if (poke && k == 6) start_in = 1'b0;
            @(posedge clk); #1;
            if (done_o) lat = k;
        end
        start_in = 1'b0;
        chk("latency", 64'(lat), 64'(w + 1));
        chk("busy_cycles", 64'(nbusy), 64'(w));
        chk("busy_at_done", {63'b0, busy_o}, 64'd0);
        chk("hi", {32'b0, hi_o}, {32'b0, eh});
        chk("lo", {32'b0, lo_o}, {32'b0, el});
        chk("dbz", {63'b0, dbz_o}, {63'b0, edz});
        prev_hi = eh;
        prev_lo = el;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ndone;
        clear = 1'b1; start_in = 1'b0; sel8 = 1'b0; op_in = 2'b0; a_in = '0; b_in = '0;
        prev_hi = '0; prev_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {62'b0, busy32, busy8}, 64'd0);
        chk("rst_done", {62'b0, done32, done8}, 64'd0);
        chk("rst_dbz", {62'b0, dbz32, dbz8}, 64'd0);
        chk("rst_hilo", {hi32, lo32}, 64'd0);
        chk("rst_hilo8", {48'b0, hi8, lo8}, 64'd0);
        clear = 1'b0;

        issue(2'b00, 32'hFFFFFFF9, 32'd6, 1'b0);
        issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        issue(2'b01, 32'hFFFFFFF9, 32'd2, 1'b0);
        issue(2'b11, 32'd100, 32'd0, 1'b1);
        issue(2'b11, 32'd100, 32'd7, 1'b0);
        issue(2'b01, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        issue(2'b01, 32'd5, 32'd0, 1'b0);

        // Abandon an op with clear after an ignored mid-op start.
        start_in = 1'b1; op_in = 2'b00; a_in = 32'd5; b_in = 32'd7;
        @(posedge clk); #1;
        start_in = 1'b0;
        for (int k = 1; k < 10; k++) begin
            start_in = (k == 5);
            @(posedge clk); #1;
        end
        start_in = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_busy", {63'b0, busy32}, 64'd0);
        chk("clr_done", {63'b0, done32}, 64'd0);
        chk("clr_dbz", {63'b0, dbz32}, 64'd0);
        chk("clr_hilo", {hi32, lo32}, 64'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done32 || busy32) ndone++;
        end
        chk("clr_no_done", 64'(ndone), 64'd0);
        prev_hi = '0; prev_lo = '0;
        issue(2'b00, 32'd3, 32'd4, 1'b0);

        for (int i = 0; i < 30; i++)
            issue(2'($urandom), pick(), pick(), $urandom_range(0, 3) == 0);

        sel8 = 1'b1; prev_hi = '0; prev_lo = '0;
        issue(2'b01, 32'h81, 32'h0A, 1'b0);
        for (int i = 0; i < 25; i++)
            issue(2'($urandom), {24'b0, 8'($urandom)}, {24'b0, 8'($urandom_range(0, 3) == 0 ? 0 : $urandom)},
                  $urandom_range(0, 3) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
